// File: rtl/cpu_pkg.sv
// Shared datapath constants and the per-cycle PC action encoding for the lab CPU.
// The action select lives here so every consumer agrees on request priority.
package cpu_pkg;

    localparam int              PC_W                = 16;
    localparam logic [PC_W-1:0] RESET_PC_DEFAULT    = 16'h0000;
    localparam int              STACK_DEPTH_DEFAULT = 4;
    localparam int              PTR_W_DEFAULT       = 2;

    typedef enum logic [2:0] {
        PC_ACT_HOLD,
        PC_ACT_RET,
        PC_ACT_RET_EMPTY,
        PC_ACT_CALL,
        PC_ACT_BRANCH,
        PC_ACT_SEQ
    } pc_act_e;

    // Priority: stall > ret > call > branch > sequential (reset handled by the registers).
    function automatic pc_act_e pc_select(
        input logic stall,
        input logic ret_en,
        input logic call_en,
        input logic branch_en,
        input logic stack_empty
    );
        pc_act_e act;
        if (stall)
            act = PC_ACT_HOLD;
        else if (ret_en)
            act = stack_empty ? PC_ACT_RET_EMPTY : PC_ACT_RET;
        else if (call_en)
            act = PC_ACT_CALL;
        else if (branch_en)
            act = PC_ACT_BRANCH;
        else
            act = PC_ACT_SEQ;
        return act;
    endfunction

endpackage

// File: rtl/pc_unit_ret_stack.sv
// Return-address LIFO; the pointer counts 0..DEPTH so full and empty are both encodable.
// Entry storage is not reset because its contents are meaningless until pushed.
module ret_stack
    import cpu_pkg::*;
#(
    parameter int DEPTH  = STACK_DEPTH_DEFAULT,
    parameter int PTR_W  = PTR_W_DEFAULT,
    parameter int DATA_W = PC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] top_data,
    output logic              empty,
    output logic              full
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W:0]    ptr_q;
    logic [PTR_W:0]    ptr_d;
    logic [PTR_W:0]    top_ptr;
    logic [DATA_W-1:0] mem_q [DEPTH];

    assign empty   = (ptr_q == '0);
    assign full    = (ptr_q == FULL_CNT);
    assign top_ptr = ptr_q - 1'b1;
    assign top_data = mem_q[top_ptr[PTR_W-1:0]];

    always_comb begin
        ptr_d = ptr_q;
        if (pop && !empty)
            ptr_d = ptr_q - 1'b1;
        else if (push && !full)
            ptr_d = ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            ptr_q <= '0;
        else
            ptr_q <= ptr_d;
    end

    always_ff @(posedge clk) begin
        if (!rst && push && !pop && !full)
            mem_q[ptr_q[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: PC register, sequential/redirect targets for the downstream
// next-PC mux, and call/return handling through a small hardware return stack.
module pc_unit
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int              STACK_DEPTH = STACK_DEPTH_DEFAULT,
    parameter int              PTR_W       = PTR_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branch_en,
    input  logic [PC_W-1:0] branch_target,
    input  logic            call_en,
    input  logic            ret_en,
    output logic [PC_W-1:0] pc_out,
    output logic [PC_W-1:0] pc_seq,
    output logic [PC_W-1:0] pc_redirect,
    output logic            redirect,
    output logic            stack_empty,
    output logic            stack_full,
    output logic            stack_err
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic            err_q;
    logic            err_d;
    logic            push;
    logic            pop;
    logic [PC_W-1:0] top_data;
    pc_act_e         act;

    assign act = pc_select(stall, ret_en, call_en, branch_en, stack_empty);

    ret_stack #(
        .DEPTH  (STACK_DEPTH),
        .PTR_W  (PTR_W),
        .DATA_W (PC_W)
    ) u_ret_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (pc_seq),
        .top_data  (top_data),
        .empty     (stack_empty),
        .full      (stack_full)
    );

    assign pc_out    = pc_q;
    assign pc_seq    = pc_q + 1'b1;
    assign stack_err = err_q;

    // A call on a full stack still jumps; only the push is dropped and flagged.
    always_comb begin
        pc_d        = pc_seq;
        err_d       = err_q;
        push        = 1'b0;
        pop         = 1'b0;
        redirect    = 1'b0;
        pc_redirect = branch_target;
        case (act)
            PC_ACT_HOLD: begin
                pc_d = pc_q;
            end
            PC_ACT_RET: begin
                pop         = 1'b1;
                redirect    = 1'b1;
                pc_redirect = top_data;
                pc_d        = top_data;
            end
            PC_ACT_RET_EMPTY: begin
                err_d = 1'b1;
            end
            PC_ACT_CALL: begin
                redirect = 1'b1;
                pc_d     = branch_target;
                if (stack_full)
                    err_d = 1'b1;
                else
                    push = 1'b1;
            end
            PC_ACT_BRANCH: begin
                redirect = 1'b1;
                pc_d     = branch_target;
            end
            default: begin
                pc_d = pc_seq;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: fixed vector table, hand-built call/return corner
// sequences and a random phase, all compared against a queue-based reference model.
module tb_pc_unit;
    import cpu_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        branch_en = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic        call_en = 1'b0;
    logic        ret_en = 1'b0;
    logic [15:0] pc_out;
    logic [15:0] pc_seq;
    logic [15:0] pc_redirect;
    logic        redirect;
    logic        stack_empty;
    logic        stack_full;
    logic        stack_err;

    int checks = 0;
    int errors = 0;

    logic [15:0] mPc = 16'h0000;
    logic [15:0] mStack[$];
    logic        mErr = 1'b0;
    logic        sampledRedir;

    typedef struct {
        logic        r;
        logic        s;
        logic        b;
        logic        c;
        logic        rt;
        logic [15:0] t;
        logic [15:0] expPc;
        logic        expRedir;
        logic        expEmpty;
        logic        expErr;
    } vec_t;

    vec_t vecs[14];

    pc_unit #(
        .RESET_PC    (16'h0000),
        .STACK_DEPTH (DEPTH),
        .PTR_W       (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .call_en       (call_en),
        .ret_en        (ret_en),
        .pc_out        (pc_out),
        .pc_seq        (pc_seq),
        .pc_redirect   (pc_redirect),
        .redirect      (redirect),
        .stack_empty   (stack_empty),
        .stack_full    (stack_full),
        .stack_err     (stack_err)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock of stimulus: combinational outputs are checked mid-cycle, state after the edge.
    task automatic applyStimulus(input logic r, input logic s, input logic b,
                                 input logic c, input logic rt, input logic [15:0] t);
        logic        expRedir;
        logic [15:0] expRedirPc;
        logic [15:0] seqPc;
        logic [15:0] nextPc;
        @(negedge clk);
        rst = r;
        stall = s;
        branch_en = b;
        call_en = c;
        ret_en = rt;
        branch_target = t;
        #1;
        seqPc = mPc + 16'd1;
        expRedir = 1'b0;
        expRedirPc = t;
        nextPc = seqPc;
        if (r) begin
            nextPc = 16'h0000;
            mStack.delete();
            mErr = 1'b0;
        end else if (s) begin
            nextPc = mPc;
        end else if (rt && mStack.size() > 0) begin
            expRedir = 1'b1;
            expRedirPc = mStack.pop_back();
            nextPc = expRedirPc;
        end else if (rt) begin
            mErr = 1'b1;
        end else if (c) begin
            expRedir = 1'b1;
            nextPc = t;
            if (mStack.size() < DEPTH)
                mStack.push_back(seqPc);
            else
                mErr = 1'b1;
        end else if (b) begin
            expRedir = 1'b1;
            nextPc = t;
        end
        sampledRedir = redirect;
        if (!r) begin
            checkOutput("redirect", {15'd0, redirect}, {15'd0, expRedir});
            checkOutput("pc_redirect", pc_redirect, expRedirPc);
            checkOutput("pc_seq", pc_seq, seqPc);
        end
        @(posedge clk);
        #1;
        mPc = nextPc;
        checkOutput("pc_out", pc_out, mPc);
        checkOutput("stack_empty", {15'd0, stack_empty}, {15'd0, mStack.size() == 0});
        checkOutput("stack_full", {15'd0, stack_full}, {15'd0, mStack.size() == DEPTH});
        checkOutput("stack_err", {15'd0, stack_err}, {15'd0, mErr});
    endtask

    initial begin
        logic [15:0] retExp[4];

        //           r     s     b     c     rt    target    pc        redir empty err
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0002, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0003, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0010, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0100, 16'h0100, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0101, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0102, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0011, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFE, 16'hFFFE, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0};

        $display("[TB] vector table");
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].r, vecs[i].s, vecs[i].b, vecs[i].c, vecs[i].rt, vecs[i].t);
            if (!vecs[i].r)
                checkOutput($sformatf("vec%0d redirect", i), {15'd0, sampledRedir}, {15'd0, vecs[i].expRedir});
            checkOutput($sformatf("vec%0d pc_out", i), pc_out, vecs[i].expPc);
            checkOutput($sformatf("vec%0d stack_empty", i), {15'd0, stack_empty}, {15'd0, vecs[i].expEmpty});
            checkOutput($sformatf("vec%0d stack_err", i), {15'd0, stack_err}, {15'd0, vecs[i].expErr});
        end

        $display("[TB] nested calls and overflow/underflow");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'(16'h0200 + i));
            if (i == 3) begin
                checkOutput("nest full after 4", {15'd0, stack_full}, 16'd1);
                checkOutput("nest err after 4", {15'd0, stack_err}, 16'd0);
            end
        end
        checkOutput("nest 5th pc", pc_out, 16'h0204);
        checkOutput("nest 5th err", {15'd0, stack_err}, 16'd1);
        retExp[0] = 16'h0203;
        retExp[1] = 16'h0202;
        retExp[2] = 16'h0201;
        retExp[3] = 16'h0001;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
            checkOutput($sformatf("ret%0d pc", i), pc_out, retExp[i]);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        checkOutput("ret underflow pc", pc_out, 16'h0002);
        checkOutput("ret underflow empty", {15'd0, stack_empty}, 16'd1);
        checkOutput("ret underflow err", {15'd0, stack_err}, 16'd1);

        $display("[TB] call and ret together");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0041);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0500);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0600);
        checkOutput("callret redirect", {15'd0, sampledRedir}, 16'd1);
        checkOutput("callret pc", pc_out, 16'h0042);
        checkOutput("callret empty", {15'd0, stack_empty}, 16'd1);

        $display("[TB] stall over branch");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0300);
            checkOutput($sformatf("stall%0d redirect", i), {15'd0, sampledRedir}, 16'd0);
            checkOutput($sformatf("stall%0d pc", i), pc_out, 16'h0000);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0300);
        checkOutput("unstall pc", pc_out, 16'h0300);

        $display("[TB] reset during call sequence");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0700);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0700);
        checkOutput("rst mid pc", pc_out, 16'h0000);
        checkOutput("rst mid empty", {15'd0, stack_empty}, 16'd1);
        checkOutput("rst mid err", {15'd0, stack_err}, 16'd0);

        $display("[TB] random phase");
        for (int i = 0; i < 500; i++) begin
            applyStimulus($urandom_range(0, 39) == 0,
                          $urandom_range(0, 5) == 0,
                          $urandom_range(0, 2) == 0,
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 3) == 0,
                          16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
